// File: rtl/seq_divider_8bits_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default widths and the quotient pattern reported on division by zero.
package seq_divider_8bits_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [DEF_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/seq_divider_8bits_div_step_unit.sv
// One combinational restoring-division step: shift {P,Q} left, trial-subtract
// D from P, keep the difference and set the quotient bit when no borrow.
module div_step_unit
  import seq_divider_8bits_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH+1:0] p_shift;
  logic [WIDTH+1:0] trial;
  logic             borrow;

  // P stays below D between steps, so the extra top bit only ever holds zero;
  // carrying it keeps the subtract exact without discarding any input bit.
  always_comb begin
    p_shift = {p, q[WIDTH-1]};
    trial   = p_shift - {2'b00, d};
    borrow  = trial[WIDTH+1];
    p_next  = borrow ? p_shift[WIDTH:0] : trial[WIDTH:0];
    q_next  = {q[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/seq_divider_8bits.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// registered quotient/remainder with a one-cycle done strobe.
module seq_divider_8bits
  import seq_divider_8bits_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W   // 2**CNT_W must exceed WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   p_reg;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] d_reg;
  logic             last_step;

  div_step_unit #(.WIDTH(WIDTH)) u_step (
    .p      (p_reg),
    .q      (q_reg),
    .d      (d_reg),
    .p_next (p_next),
    .q_next (q_next)
  );

  assign last_step = (count == CNT_W'(1));
  assign busy      = (state == ST_CALC);
  assign done      = (state == ST_DONE);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = (divisor == '0) ? ST_DONE : ST_CALC;
      ST_CALC: if (last_step) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      p_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            q_reg       <= dividend;
            d_reg       <= divisor;
            p_reg       <= '0;
            count       <= CNT_W'(WIDTH);
            div_by_zero <= 1'b0;
            // Zero divisor skips the iteration and reports immediately.
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          p_reg <= p_next;
          q_reg <= q_next;
          count <= count - CNT_W'(1);
          if (last_step) begin
            quotient  <= q_next;
            remainder <= p_next[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_8bits.sv
// Directed bench for seq_divider_8bits: latency, results, held outputs,
// ignored starts, division by zero and mid-operation reset.
module tb_seq_divider_8bits;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int tests;
  int fails;
  int lat;
  int busy_cnt;
  logic got_done;

  seq_divider_8bits dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands with start at a falling edge; the next rising edge is E0.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count falling edges after E0 until done, bounded so a stuck DUT still ends.
  task automatic wait_done();
    lat      = 0;
    busy_cnt = 0;
    got_done = 1'b0;
    while (!got_done && lat < 30) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (done) got_done = 1'b1;
    end
    check("done_seen", 32'(got_done), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic ez);
    int exp_lat;
    exp_lat = (b == 8'd0) ? 1 : 9;
    start_op(a, b);
    wait_done();
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    check({tag, "_quot"}, 32'(quotient), 32'(eq));
    check({tag, "_rem"}, 32'(remainder), 32'(er));
    check({tag, "_dz"}, 32'(div_by_zero), 32'(ez));
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 8'd99;
    divisor  = 8'd3;

    // Reset wins over start.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quot", 32'(quotient), 32'd0);
    check("rst_rem", 32'(remainder), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    start = 1'b0;
    rst   = 1'b0;

    run_op("d200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0);

    run_op("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    repeat (4) @(negedge clk);
    check("hold_done", 32'(done), 32'd0);
    check("hold_quot", 32'(quotient), 32'd255);
    check("hold_rem", 32'(remainder), 32'd0);
    run_op("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);

    run_op("d77_0", 8'd77, 8'd0, 8'd255, 8'd77, 1'b1);
    run_op("d10_3", 8'd10, 8'd3, 8'd3, 8'd1, 1'b0);

    // start held through CALC and DONE with different operands.
    start_op(8'd100, 8'd10);
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd2;
    wait_done();
    check("ign_lat", 32'(lat), 32'd9);
    check("ign_quot", 32'(quotient), 32'd10);
    check("ign_rem", 32'(remainder), 32'd0);
    @(negedge clk);
    check("ign_idle_busy", 32'(busy), 32'd0);
    check("ign_idle_done", 32'(done), 32'd0);
    start = 1'b0;
    @(negedge clk);
    check("ign_no_restart", 32'(busy), 32'd0);
    check("ign_hold_quot", 32'(quotient), 32'd10);

    // Abort in the 4th CALC cycle.
    start_op(8'd250, 8'd3);
    repeat (4) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quot", 32'(quotient), 32'd0);
    check("abort_rem", 32'(remainder), 32'd0);
    check("abort_dz", 32'(div_by_zero), 32'd0);
    got_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) got_done = 1'b1;
    end
    check("abort_quiet", 32'(got_done), 32'd0);
    run_op("d250_3", 8'd250, 8'd3, 8'd83, 8'd1, 1'b0);

    // Operand extremes.
    run_op("d0_0", 8'd0, 8'd0, 8'd255, 8'd0, 1'b1);
    run_op("d0_5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0);
    run_op("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    run_op("d254_255", 8'd254, 8'd255, 8'd0, 8'd254, 1'b0);
    run_op("d255_128", 8'd255, 8'd128, 8'd1, 8'd127, 1'b0);
    run_op("d128_2", 8'd128, 8'd2, 8'd64, 8'd0, 1'b0);

    // Sampled sweep against integer division.
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 17 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (b == 8'd0) run_op("rnd", a, b, 8'd255, a, 1'b1);
      else           run_op("rnd", a, b, a / b, a % b, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
